// File: rtl/ibex_vector_window_gen.sv
// Streaming 3x3 window generator: raster-order 8-bit pixels in, fully-interior
// 3x3 neighbourhoods out as packed 128-bit vector operands with valid/ready.
module ibex_vector_window_gen #(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         pix_valid_i,
  input  logic [7:0]   pix_data_i,
  output logic         pix_ready_o,
  output logic         win_valid_o,
  input  logic         win_ready_i,
  output logic [127:0] win_o,
  output logic         frame_done_o
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;
  logic [7:0]     lb0 [IMG_WIDTH];
  logic [7:0]     lb1 [IMG_WIDTH];
  // Only the two most recent window columns are stored; the third is the
  // incoming column, so the shifted window is formed combinationally.
  logic [23:0]    wcol_a;
  logic [23:0]    wcol_b;
  logic [23:0]    new_col;
  logic [71:0]    cols;
  logic [127:0]   shifted;
  logic           accept;
  logic           last_col;
  logic           last_row;
  logic           emit;

  assign pix_ready_o = !rst_i && !clear_i && (!win_valid_o || win_ready_i);
  assign accept      = pix_valid_i && pix_ready_o;
  assign last_col    = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row    = (row_q == RW'(IMG_HEIGHT - 1));
  assign emit        = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign new_col     = {lb1[col_q], lb0[col_q], pix_data_i};
  assign cols        = {new_col, wcol_b, wcol_a};

  // Column j holds {top, mid, bottom}; byte 3*i+j takes row i of column j.
  always_comb begin
    shifted = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        shifted[8*(3*i+j) +: 8] = cols[24*j + 8*(2-i) +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb1[col_q] <= lb0[col_q];
      lb0[col_q] <= pix_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q        <= '0;
      row_q        <= '0;
      wcol_a       <= '0;
      wcol_b       <= '0;
      win_o        <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else if (clear_i) begin
      col_q        <= '0;
      row_q        <= '0;
      wcol_a       <= '0;
      wcol_b       <= '0;
      win_o        <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (accept) begin
        wcol_a <= wcol_b;
        wcol_b <= new_col;
        if (last_col) begin
          col_q <= '0;
          if (last_row) begin
            row_q        <= '0;
            frame_done_o <= 1'b1;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
      if (accept && emit) begin
        win_o       <= shifted;
        win_valid_o <= 1'b1;
      end else if (win_ready_i) begin
        win_valid_o <= 1'b0;
      end
    end
  end

endmodule
